alu_cmd_queue: RTL and testbench
================================

ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width.
REQ-002 Parameter: DEPTH, 4, command FIFO entries (power of two, >=2).
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command slot free.
REQ-008 cmd_a / cmd_b  in  WIDTH  operands.
REQ-009 cmd_sel  in  2  op: 00 add, 01 sub, 10 mul, 11 div.
REQ-010 alu_ina / alu_inb  out  WIDTH  operands to combinational ALU.
REQ-011 alu_sel  out  2  op select to ALU.
REQ-012 alu_out  in  WIDTH  ALU result.
REQ-013 alu_ovf  in  1  ALU overflow.
REQ-014 res_valid  out  1  result available.
REQ-015 res_ready  in  1  consumer accepts result.
REQ-016 res_data  out  WIDTH  captured result.
REQ-017 res_ovf  out  1  overflow of res_data.
REQ-018 ovf_sticky  out  1  any overflow since last clear.
REQ-019 ovf_clr  in  1  clears ovf_sticky.
REQ-020 count  out  log2(DEPTH)+1  queued entries (excludes in-flight op).

Function
REQ-021 Push on cmd_valid&&cmd_ready; cmd_ready SHALL be (count<DEPTH) from registered count only (no same-cycle pop credit).
REQ-022 FIFO order SHALL be strict; read/write pointers wrap modulo DEPTH.
REQ-023 Push and pop in same cycle SHALL leave count unchanged.
REQ-024 Issue FSM states IDLE, DRIVE, HOLD.
REQ-025 IDLE: if count>0, pop head into operand/sel registers, go DRIVE; else stay.
REQ-026 DRIVE: alu_ina/alu_inb/alu_sel driven from registers; at edge capture alu_out->res_data, alu_ovf->res_ovf, set res_valid, go HOLD.
REQ-027 HOLD: res_data/res_ovf/res_valid SHALL stay stable while res_ready=0.
REQ-028 HOLD with res_ready=1: clear res_valid; if count>0 pop next and go DRIVE, else go IDLE.
REQ-029 Latency: res_valid high 2 cycles after accepting edge into empty queue in IDLE; steady-state throughput one result per 2 cycles.
REQ-030 ovf_sticky set on capture with alu_ovf=1; cleared by ovf_clr; simultaneous set and clear SHALL leave it set.
REQ-031 Block SHALL not interpret cmd_sel; div-by-zero/overflow semantics belong to ALU.
REQ-032 alu_* outputs SHALL hold last issued values in IDLE/HOLD.

Reset
REQ-033 rst SHALL immediately force: state IDLE, pointers/count 0, cmd_ready 1 (after asynchronous clear), res_valid 0, res_data 0, res_ovf 0, ovf_sticky 0, alu_ina/alu_inb 0, alu_sel 00.
REQ-034 Reset mid-operation SHALL discard queued and in-flight commands; no stale result after release.

Structure
REQ-035 Shared package alu_pkg SHALL hold WIDTH default, op encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and FSM state type.
REQ-036 FIFO SHALL be sub-module alu_cmd_fifo (storage, pointers, count); FSM and result registers in alu_cmd_queue.

Verification
REQ-037 Push a=0x0003,b=0x0004,sel=00, model ALU returns 0x0007 -> res_valid 2 cycles later, res_data 0x0007, res_ovf 0.
REQ-038 res_ready=0, offer 6 back-to-back commands -> 5 accepted, cmd_ready 0, count=4, first result held stable.
REQ-039 0x7FFF+0x0001 with alu_ovf=1 -> res_ovf 1, ovf_sticky 1 until ovf_clr; ovf_clr coincident with new overflow -> ovf_sticky stays 1.
REQ-040 Continuous res_ready=1, 10 queued ops with distinct operands -> results in order, res_valid low exactly one cycle between results, pointers wrap correctly.
REQ-041 rst asserted in DRIVE with 3 queued -> all outputs reset values same cycle; after release count 0, no res_valid without new command.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU command queue
package alu_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        HOLD  = 2'b10
    } issue_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO: storage, wrapping pointers and occupancy count
module alu_cmd_fifo #(
    parameter int DW    = 34,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic [CW-1:0] count,
    output logic          ready
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    // Space is judged only from the registered count; a pop this cycle gives no credit.
    assign ready = (count_q < FULL_CNT);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (natural power-of-two wrap) and count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_ok  = push && ready;
        pop_ok   = pop && (count_q != '0);
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// rtl/alu_cmd_queue.sv - queues ALU commands, issues them one at a time and holds results
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_sel,
    output logic [WIDTH-1:0] alu_ina,
    output logic [WIDTH-1:0] alu_inb,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic [CW-1:0]    count
);

    localparam int DW = 2 * WIDTH + 2;

    issue_state_e     state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    alu_op_e          op_sel_q, op_sel_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_valid_q, res_valid_d;
    logic             ovf_sticky_q, ovf_sticky_d;

    logic [DW-1:0]    fifo_wdata;
    logic [DW-1:0]    fifo_rdata;
    logic [CW-1:0]    fifo_count;
    logic             fifo_ready;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_has_cmd;
    logic             capture;

    // Commands are stored as {a, b, sel}; sel is passed through uninterpreted.
    assign fifo_wdata   = {cmd_a, cmd_b, cmd_sel};
    assign fifo_push    = cmd_valid && fifo_ready;
    assign fifo_has_cmd = (fifo_count != '0);

    alu_cmd_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .ready (fifo_ready)
    );

    assign cmd_ready  = fifo_ready;
    assign count      = fifo_count;
    assign alu_ina    = op_a_q;
    assign alu_inb    = op_b_q;
    assign alu_sel    = op_sel_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_ovf    = res_ovf_q;
    assign ovf_sticky = ovf_sticky_q;

    // Issue FSM: pop into operand registers, sample the ALU for one cycle, hold until taken.
    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_sel_d     = op_sel_q;
        res_data_d   = res_data_q;
        res_ovf_d    = res_ovf_q;
        res_valid_d  = res_valid_q;
        ovf_sticky_d = ovf_sticky_q;
        fifo_pop     = 1'b0;
        capture      = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_has_cmd) begin
                    fifo_pop = 1'b1;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                capture     = 1'b1;
                res_data_d  = alu_out;
                res_ovf_d   = alu_ovf;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (fifo_has_cmd) begin
                        fifo_pop = 1'b1;
                        state_d  = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (fifo_pop) begin
            op_a_d   = fifo_rdata[DW-1 -: WIDTH];
            op_b_d   = fifo_rdata[2 +: WIDTH];
            op_sel_d = alu_op_e'(fifo_rdata[1:0]);
        end
        // A new overflow in the same cycle as a clear must win.
        if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end
        if (capture && alu_ovf) begin
            ovf_sticky_d = 1'b1;
        end
    end

    // FSM, operand and result registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sel_q     <= OP_ADD;
            res_data_q   <= '0;
            res_ovf_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_sel_q     <= op_sel_d;
            res_data_q   <= res_data_d;
            res_ovf_q    <= res_ovf_d;
            res_valid_q  <= res_valid_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb/tb_alu_cmd_queue.sv - self-checking bench for alu_cmd_queue
module tb_alu_cmd_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [1:0]  cmd_sel = '0;
    logic [15:0] alu_ina, alu_inb;
    logic [1:0]  alu_sel;
    logic [15:0] alu_out;
    logic        alu_ovf;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_ovf;
    logic        ovf_sticky;
    logic        ovf_clr = 1'b0;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  sel;
        logic [15:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[8];

    alu_cmd_queue #(.WIDTH(16), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_sel    (cmd_sel),
        .alu_ina    (alu_ina),
        .alu_inb    (alu_inb),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_ovf    (alu_ovf),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_ovf    (res_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: {ovf, result}; signed overflow for add/sub, lost high bits for mul, div by zero.
    function automatic logic [16:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] sel);
        logic [15:0] s;
        logic [31:0] p;
        case (sel)
            2'b00: begin
                s = a + b;
                return {(a[15] == b[15]) && (s[15] != a[15]), s};
            end
            2'b01: begin
                s = a - b;
                return {(a[15] != b[15]) && (s[15] != a[15]), s};
            end
            2'b10: begin
                p = 32'(a) * 32'(b);
                return {|p[31:16], p[15:0]};
            end
            default: begin
                if (b == 16'h0) return {1'b1, 16'hFFFF};
                return {1'b0, a / b};
            end
        endcase
    endfunction

    assign {alu_ovf, alu_out} = alu_ref(alu_ina, alu_inb, alu_sel);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_ovf"}, res_ovf, 0);
        chk({tag, "_ovf_sticky"}, ovf_sticky, 0);
        chk({tag, "_alu_ina"}, alu_ina, 0);
        chk({tag, "_alu_inb"}, alu_inb, 0);
        chk({tag, "_alu_sel"}, alu_sel, 0);
        chk({tag, "_count"}, count, 0);
    endtask

    // Streams n_ops random commands through a queue-of-results model.
    task automatic run_stream(input int n_ops, input bit rnd_ready, input bit check_gap);
        logic [16:0] expq[$];
        logic [16:0] e;
        int pushed = 0;
        int got = 0;
        int low_run = 0;
        int cyc = 0;
        bit seen = 0;
        bit prev_valid = 0;
        bit prev_ready = 0;
        logic [15:0] prev_data = '0;
        logic prev_ovf = 0;
        res_ready = 1'b1;
        while (got < n_ops && cyc < 3000) begin
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", res_valid, 1);
                chk("hold_data", res_data, prev_data);
                chk("hold_ovf", res_ovf, prev_ovf);
            end
            if (res_valid && !prev_valid) begin
                if (check_gap && seen) chk("gap_one_cycle", low_run, 1);
                seen = 1;
                low_run = 0;
            end
            if (!res_valid) low_run++;
            if (pushed < n_ops && (!rnd_ready || $urandom_range(0, 3) != 0)) begin
                cmd_valid = 1'b1;
                cmd_a     = 16'($urandom);
                cmd_b     = 16'($urandom);
                cmd_sel   = 2'($urandom_range(0, 3));
            end else begin
                cmd_valid = 1'b0;
            end
            if (rnd_ready) res_ready = 1'($urandom_range(0, 1));
            if (cmd_valid && cmd_ready) begin
                expq.push_back(alu_ref(cmd_a, cmd_b, cmd_sel));
                pushed++;
            end
            if (res_valid && res_ready) begin
                if (expq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL stream_unexpected: result 0x%0h with no command outstanding", res_data);
                end else begin
                    e = expq.pop_front();
                    chk("stream_data", res_data, e[15:0]);
                    chk("stream_ovf", res_ovf, e[16]);
                end
                got++;
            end
            prev_valid = res_valid;
            prev_ready = res_ready;
            prev_data  = res_data;
            prev_ovf   = res_ovf;
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        chk("stream_results", got, n_ops);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bp_exp[$];
        int accepted;
        int waited;

        vecs[0] = '{16'h0003, 16'h0004, 2'b00, 16'h0007, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 2'b00, 16'h8000, 1'b1};
        vecs[2] = '{16'h0005, 16'h0007, 2'b01, 16'hFFFE, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 2'b01, 16'h7FFF, 1'b1};
        vecs[4] = '{16'h0100, 16'h0100, 2'b10, 16'h0000, 1'b1};
        vecs[5] = '{16'h0010, 16'h0011, 2'b10, 16'h0110, 1'b0};
        vecs[6] = '{16'h0064, 16'h0007, 2'b11, 16'h000E, 1'b0};
        vecs[7] = '{16'h0005, 16'h0000, 2'b11, 16'hFFFF, 1'b1};

        // reset values while held in reset
        #1;
        check_reset_vals("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // single commands into an empty idle queue: latency, result, overflow flags
        for (int i = 0; i < 8; i++) begin
            chk("vec_cmd_ready", cmd_ready, 1);
            cmd_valid = 1'b1;
            cmd_a     = vecs[i].a;
            cmd_b     = vecs[i].b;
            cmd_sel   = vecs[i].sel;
            tick();
            cmd_valid = 1'b0;
            chk("vec_lat_edge1", res_valid, 0);
            tick();
            chk("vec_lat_edge2", res_valid, 0);
            chk("vec_drive_a", alu_ina, vecs[i].a);
            chk("vec_drive_b", alu_inb, vecs[i].b);
            chk("vec_drive_sel", alu_sel, vecs[i].sel);
            tick();
            chk("vec_res_valid", res_valid, 1);
            chk("vec_res_data", res_data, vecs[i].exp_data);
            chk("vec_res_ovf", res_ovf, vecs[i].exp_ovf);
            chk("vec_sticky", ovf_sticky, vecs[i].exp_ovf);
            res_ready = 1'b1;
            ovf_clr   = 1'b1;
            tick();
            res_ready = 1'b0;
            ovf_clr   = 1'b0;
            chk("vec_res_taken", res_valid, 0);
            chk("vec_sticky_clr", ovf_sticky, 0);
            chk("vec_alu_hold_a", alu_ina, vecs[i].a);
        end

        // backpressure: six offered back-to-back, five fit (one in flight + four queued)
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 16'(16'h0011 * (i + 1));
            cmd_b     = 16'(i);
            cmd_sel   = 2'b00;
            if (cmd_ready) begin
                accepted++;
                bp_exp.push_back(cmd_a + cmd_b);
            end
            tick();
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", accepted, 5);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_count", count, 4);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", res_valid, 1);
            chk("bp_hold_data", res_data, bp_exp[0]);
            tick();
        end
        res_ready = 1'b1;
        waited = 0;
        while (bp_exp.size() > 0 && waited < 100) begin
            if (res_valid) chk("bp_drain_data", res_data, bp_exp.pop_front());
            tick();
            waited++;
        end
        res_ready = 1'b0;
        chk("bp_drained", bp_exp.size(), 0);
        tick();

        // sticky overflow: hold until cleared, and set wins over a coincident clear
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("sticky_pre", ovf_sticky, 0);
        cmd_valid = 1'b1; cmd_a = 16'h7FFF; cmd_b = 16'h0001; cmd_sel = 2'b00;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("ovf_res_data", res_data, 16'h8000);
        chk("ovf_res_ovf", res_ovf, 1);
        chk("ovf_sticky_set", ovf_sticky, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        tick();
        chk("ovf_sticky_hold", ovf_sticky, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_sticky_clr", ovf_sticky, 0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_set_wins_valid", res_valid, 1);
        chk("ovf_set_wins", ovf_sticky, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();

        // continuous consumer: ordered results, one idle cycle between them, pointer wrap
        run_stream(10, 1'b0, 1'b1);
        tick();
        // random producer/consumer handshakes
        run_stream(40, 1'b1, 1'b0);
        tick();
        tick();

        // reset while an op is in DRIVE with three commands queued
        chk("rr_idle", res_valid, 0);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 16'(16'h0100 + i);
            cmd_b     = 16'h0002;
            cmd_sel   = 2'b10;
            tick();
        end
        cmd_valid = 1'b0;
        chk("rr_count_full", count, 4);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("rr_drive_count", count, 3);
        chk("rr_drive_valid", res_valid, 0);
        rst = 1'b1;
        #1;
        check_reset_vals("rr_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_post_valid", res_valid, 0);
            chk("rr_post_count", count, 0);
            chk("rr_post_ready", cmd_ready, 1);
        end
        res_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
